// File: rtl/bp_be_thread_status_mt.sv
// -----------------------------------------------------------------------------
// bp_be_thread_status_mt
//
// Purpose:
//   Tracks the run state of every hardware thread context and presents it to
//   the MT scheduler. Each thread is OFF, RUN or BLOCK.
//     - A CSR write enables or disables a thread.
//     - A retired mwait blocks a running thread on a monitored cache line,
//       with an optional timeout.
//     - A blocked thread wakes on any of these events:
//         * an explicit wake (IPI), which has the highest priority;
//         * a store or invalidate snoop that hits its line;
//         * expiry of its timer.
//       A wake raises a one-cycle pulse and records its cause.
//
// Ports:
//   clk_i, reset_i     clock and synchronous active-high reset
//   csr_en_*           CSR enable/disable write (strobe, tid, value)
//   mwait_*            mwait retirement (strobe, tid, address, timeout)
//   snoop_v_i/addr_i   observed store/invalidate
//   wake_v_i/tid_i     explicit wake
//   thread_enabled_o   per thread: state != OFF (registered)
//   thread_blocked_o   per thread: state == BLOCK (registered)
//   wake_pulse_o       per thread: one-cycle pulse on a wake
//   wake_cause_o       per thread [2t+:2]: 0 snoop, 1 timeout, 2 explicit.
//                      Only meaningful in the cycle the pulse is high.
//   dbg_state_o        per thread [2t+:2]: raw FSM state, for checkers
//
// Valid/ready note:
//   All inputs are single-cycle strobes with no back-pressure. A strobe is
//   consumed in the cycle it is high. Its effect appears on the outputs in
//   the following cycle.
// -----------------------------------------------------------------------------
module bp_be_thread_status_mt #(
  parameter int num_threads_p   = 4,
  parameter int tid_width_p     = 2,
  parameter int paddr_width_p   = 40,
  parameter int line_offset_p   = 6,
  parameter int timeout_width_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         csr_en_v_i,
  input  logic [tid_width_p-1:0]       csr_en_tid_i,
  input  logic                         csr_en_val_i,
  input  logic                         mwait_v_i,
  input  logic [tid_width_p-1:0]       mwait_tid_i,
  input  logic [paddr_width_p-1:0]     mwait_addr_i,
  input  logic [timeout_width_p-1:0]   mwait_timeout_i,
  input  logic                         snoop_v_i,
  input  logic [paddr_width_p-1:0]     snoop_addr_i,
  input  logic                         wake_v_i,
  input  logic [tid_width_p-1:0]       wake_tid_i,
  output logic [num_threads_p-1:0]     thread_enabled_o,
  output logic [num_threads_p-1:0]     thread_blocked_o,
  output logic [num_threads_p-1:0]     wake_pulse_o,
  output logic [2*num_threads_p-1:0]   wake_cause_o,
  output logic [2*num_threads_p-1:0]   dbg_state_o
);

  localparam int line_width_lp = paddr_width_p - line_offset_p;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_BLOCK = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_SNOOP   = 2'd0;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
  localparam logic [1:0] CAUSE_WAKE    = 2'd2;

  // Per-thread state
  state_e                      r_state   [num_threads_p];
  state_e                      w_state_n [num_threads_p];
  logic [line_width_lp-1:0]    r_line    [num_threads_p];
  logic [line_width_lp-1:0]    w_line_n  [num_threads_p];
  logic [timeout_width_p-1:0]  r_tmr     [num_threads_p];
  logic [timeout_width_p-1:0]  w_tmr_n   [num_threads_p];
  logic [1:0]                  r_cause   [num_threads_p];
  logic [1:0]                  w_cause_n [num_threads_p];
  logic [num_threads_p-1:0]    r_tmr_en;
  logic [num_threads_p-1:0]    w_tmr_en_n;

  // Registered outputs
  logic [num_threads_p-1:0]    r_enabled;
  logic [num_threads_p-1:0]    r_blocked;
  logic [num_threads_p-1:0]    r_pulse;
  logic [num_threads_p-1:0]    w_pulse_n;

  // Per-thread decoded events
  logic [num_threads_p-1:0]    w_csr_hit;
  logic [num_threads_p-1:0]    w_mwait_hit;
  logic [num_threads_p-1:0]    w_wake_hit;
  logic [num_threads_p-1:0]    w_snoop_mon_hit;

  logic [line_width_lp-1:0]    w_snoop_line;
  logic [line_width_lp-1:0]    w_mwait_line;
  logic                        w_snoop_mwait_hit;
  logic                        w_unused_addr_bits;

  assign w_snoop_line       = snoop_addr_i[paddr_width_p-1:line_offset_p];
  assign w_mwait_line       = mwait_addr_i[paddr_width_p-1:line_offset_p];
  assign w_snoop_mwait_hit  = snoop_v_i && (w_snoop_line == w_mwait_line);
  // The byte offset within a line never matters for monitoring.
  assign w_unused_addr_bits = ^{snoop_addr_i[line_offset_p-1:0], mwait_addr_i[line_offset_p-1:0]};

  always_comb begin
    w_csr_hit       = '0;
    w_mwait_hit     = '0;
    w_wake_hit      = '0;
    w_snoop_mon_hit = '0;
    for (int t = 0; t < num_threads_p; t++) begin
      w_csr_hit[t]       = csr_en_v_i && (csr_en_tid_i == tid_width_p'(t));
      w_mwait_hit[t]     = mwait_v_i  && (mwait_tid_i  == tid_width_p'(t));
      w_wake_hit[t]      = wake_v_i   && (wake_tid_i   == tid_width_p'(t));
      w_snoop_mon_hit[t] = snoop_v_i  && (w_snoop_line == r_line[t]);
    end
  end

  // Next-state logic. The priority is: CSR disable, then CSR enable of an
  // OFF thread, then a BLOCK wake, then mwait on a RUN thread. An enable
  // aimed at a RUN or BLOCK thread is a no-op, so it does not mask the
  // lower-priority events.
  always_comb begin
    for (int t = 0; t < num_threads_p; t++) begin
      w_state_n[t]  = r_state[t];
      w_line_n[t]   = r_line[t];
      w_tmr_n[t]    = r_tmr[t];
      w_tmr_en_n[t] = r_tmr_en[t];
      w_cause_n[t]  = r_cause[t];
      w_pulse_n[t]  = 1'b0;

      if (w_csr_hit[t] && !csr_en_val_i) begin
        w_state_n[t]  = ST_OFF;
        w_tmr_n[t]    = '0;
        w_tmr_en_n[t] = 1'b0;
      end else if (w_csr_hit[t] && csr_en_val_i && (r_state[t] == ST_OFF)) begin
        w_state_n[t] = ST_RUN;
      end else begin
        unique case (r_state[t])
          ST_BLOCK: begin
            if (w_wake_hit[t]) begin
              w_pulse_n[t] = 1'b1;
              w_cause_n[t] = CAUSE_WAKE;
            end else if (w_snoop_mon_hit[t]) begin
              w_pulse_n[t] = 1'b1;
              w_cause_n[t] = CAUSE_SNOOP;
            end else if (r_tmr_en[t] && (r_tmr[t] == timeout_width_p'(1))) begin
              w_pulse_n[t] = 1'b1;
              w_cause_n[t] = CAUSE_TIMEOUT;
            end else if (r_tmr_en[t]) begin
              w_tmr_n[t] = r_tmr[t] - timeout_width_p'(1);
            end
            if (w_pulse_n[t]) begin
              w_state_n[t]  = ST_RUN;
              w_tmr_n[t]    = '0;
              w_tmr_en_n[t] = 1'b0;
            end
          end
          ST_RUN: begin
            if (w_mwait_hit[t]) begin
              w_line_n[t] = w_mwait_line;
              // Lost-wakeup guard: a wake that arrives together with the
              // mwait is honoured immediately, and the thread never blocks.
              if (w_wake_hit[t]) begin
                w_pulse_n[t] = 1'b1;
                w_cause_n[t] = CAUSE_WAKE;
              end else if (w_snoop_mwait_hit) begin
                w_pulse_n[t] = 1'b1;
                w_cause_n[t] = CAUSE_SNOOP;
              end else begin
                w_state_n[t]  = ST_BLOCK;
                w_tmr_n[t]    = mwait_timeout_i;
                w_tmr_en_n[t] = (mwait_timeout_i != '0);
              end
            end
          end
          ST_OFF: begin
            w_state_n[t] = ST_OFF;
          end
          default: begin
            w_state_n[t] = ST_OFF;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int t = 0; t < num_threads_p; t++) begin
        r_state[t] <= (t == 0) ? ST_RUN : ST_OFF;
        r_line[t]  <= '0;
        r_tmr[t]   <= '0;
        r_cause[t] <= '0;
      end
      r_tmr_en  <= '0;
      r_enabled <= num_threads_p'(1);
      r_blocked <= '0;
      r_pulse   <= '0;
    end else begin
      for (int t = 0; t < num_threads_p; t++) begin
        r_state[t]   <= w_state_n[t];
        r_line[t]    <= w_line_n[t];
        r_tmr[t]     <= w_tmr_n[t];
        r_cause[t]   <= w_cause_n[t];
        r_enabled[t] <= (w_state_n[t] != ST_OFF);
        r_blocked[t] <= (w_state_n[t] == ST_BLOCK);
      end
      r_tmr_en <= w_tmr_en_n;
      r_pulse  <= w_pulse_n;
    end
  end

  assign thread_enabled_o = r_enabled;
  assign thread_blocked_o = r_blocked;
  assign wake_pulse_o     = r_pulse;

  always_comb begin
    wake_cause_o = '0;
    dbg_state_o  = '0;
    for (int t = 0; t < num_threads_p; t++) begin
      wake_cause_o[2*t +: 2] = r_cause[t];
      dbg_state_o[2*t +: 2]  = r_state[t];
    end
  end

endmodule

// File: tb/tb_bp_be_thread_status_mt.sv
module tb_bp_be_thread_status_mt;

  localparam int NT = 4;
  localparam int TW = 2;
  localparam int AW = 40;
  localparam int LO = 6;
  localparam int TMW = 16;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            reset_i;
  logic            csr_en_v_i;
  logic [TW-1:0]   csr_en_tid_i;
  logic            csr_en_val_i;
  logic            mwait_v_i;
  logic [TW-1:0]   mwait_tid_i;
  logic [AW-1:0]   mwait_addr_i;
  logic [TMW-1:0]  mwait_timeout_i;
  logic            snoop_v_i;
  logic [AW-1:0]   snoop_addr_i;
  logic            wake_v_i;
  logic [TW-1:0]   wake_tid_i;
  logic [NT-1:0]   thread_enabled_o;
  logic [NT-1:0]   thread_blocked_o;
  logic [NT-1:0]   wake_pulse_o;
  logic [2*NT-1:0] wake_cause_o;
  logic [2*NT-1:0] dbg_state_o;

  bp_be_thread_status_mt #(
    .num_threads_p(NT), .tid_width_p(TW), .paddr_width_p(AW),
    .line_offset_p(LO), .timeout_width_p(TMW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .csr_en_v_i(csr_en_v_i), .csr_en_tid_i(csr_en_tid_i), .csr_en_val_i(csr_en_val_i),
    .mwait_v_i(mwait_v_i), .mwait_tid_i(mwait_tid_i), .mwait_addr_i(mwait_addr_i),
    .mwait_timeout_i(mwait_timeout_i),
    .snoop_v_i(snoop_v_i), .snoop_addr_i(snoop_addr_i),
    .wake_v_i(wake_v_i), .wake_tid_i(wake_tid_i),
    .thread_enabled_o(thread_enabled_o), .thread_blocked_o(thread_blocked_o),
    .wake_pulse_o(wake_pulse_o), .wake_cause_o(wake_cause_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Thread states are plain ints: 0 off, 1 running, 2 blocked. A timeout is
  // held as the absolute cycle number in which it expires.
  int            m_state [NT];
  logic [AW-LO-1:0] m_line [NT];
  bit            m_has_dl [NT];
  longint        m_dl [NT];
  longint        m_cyc;
  bit            m_valid = 1'b0;
  logic [NT-1:0] exp_en, exp_blk, exp_pulse;
  int            exp_cause [NT];

  // One compare process: at each falling edge, check the outputs produced by
  // the last rising edge, then advance the model with the inputs that the
  // next rising edge will sample.
  always @(negedge clk_i) begin
    if (m_valid) begin
      chk("enabled", 32'(thread_enabled_o), 32'(exp_en));
      chk("blocked", 32'(thread_blocked_o), 32'(exp_blk));
      chk("pulse",   32'(wake_pulse_o),     32'(exp_pulse));
      for (int t = 0; t < NT; t++)
        if (exp_pulse[t]) chk("cause", 32'(wake_cause_o[2*t +: 2]), 32'(exp_cause[t]));
    end
    if (reset_i) begin
      m_valid = 1'b1;
      m_cyc   = 0;
      for (int t = 0; t < NT; t++) begin
        m_state[t]   = (t == 0) ? 1 : 0;
        m_line[t]    = '0;
        m_has_dl[t]  = 1'b0;
        exp_cause[t] = 0;
      end
      exp_pulse = '0;
    end else if (m_valid) begin
      for (int t = 0; t < NT; t++) begin
        bit csr_hit, wake_hit, mw_hit, p;
        csr_hit  = csr_en_v_i && (csr_en_tid_i == 2'(t));
        wake_hit = wake_v_i   && (wake_tid_i   == 2'(t));
        mw_hit   = mwait_v_i  && (mwait_tid_i  == 2'(t));
        p = 1'b0;
        if (csr_hit && !csr_en_val_i) begin
          m_state[t] = 0;
          m_has_dl[t] = 1'b0;
        end else if (csr_hit && csr_en_val_i && m_state[t] == 0) begin
          m_state[t] = 1;
        end else if (m_state[t] == 2) begin
          if (wake_hit) begin p = 1'b1; exp_cause[t] = 2; end
          else if (snoop_v_i && snoop_addr_i[AW-1:LO] == m_line[t]) begin p = 1'b1; exp_cause[t] = 0; end
          else if (m_has_dl[t] && m_cyc == m_dl[t]) begin p = 1'b1; exp_cause[t] = 1; end
          if (p) begin m_state[t] = 1; m_has_dl[t] = 1'b0; end
        end else if (m_state[t] == 1 && mw_hit) begin
          if (wake_hit) begin p = 1'b1; exp_cause[t] = 2; end
          else if (snoop_v_i && snoop_addr_i[AW-1:LO] == mwait_addr_i[AW-1:LO]) begin p = 1'b1; exp_cause[t] = 0; end
          else begin
            m_state[t]  = 2;
            m_line[t]   = mwait_addr_i[AW-1:LO];
            m_has_dl[t] = (mwait_timeout_i != 0);
            m_dl[t]     = m_cyc + longint'(mwait_timeout_i);
          end
        end
        exp_pulse[t] = p;
      end
      m_cyc++;
    end
    for (int t = 0; t < NT; t++) begin
      exp_en[t]  = (m_state[t] != 0);
      exp_blk[t] = (m_state[t] == 2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    csr_en_v_i = 1'b0; csr_en_tid_i = '0; csr_en_val_i = 1'b0;
    mwait_v_i = 1'b0; mwait_tid_i = '0; mwait_addr_i = '0; mwait_timeout_i = '0;
    snoop_v_i = 1'b0; snoop_addr_i = '0;
    wake_v_i = 1'b0; wake_tid_i = '0;
  endtask

  task automatic clk1();
    @(posedge clk_i);
    #1;
  endtask

  task automatic csr(input int tid, input bit val);
    csr_en_v_i = 1'b1; csr_en_tid_i = 2'(tid); csr_en_val_i = val;
  endtask

  task automatic mwait(input int tid, input logic [AW-1:0] a, input int tmo);
    mwait_v_i = 1'b1; mwait_tid_i = 2'(tid); mwait_addr_i = a; mwait_timeout_i = 16'(tmo);
  endtask

  task automatic snoop(input logic [AW-1:0] a);
    snoop_v_i = 1'b1; snoop_addr_i = a;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset_i = 1'b1;
    idle();
    clk1(); clk1();
    chk("rst_enabled", 32'(thread_enabled_o), 32'h1);
    chk("rst_blocked", 32'(thread_blocked_o), 32'h0);
    chk("rst_pulse",   32'(wake_pulse_o),     32'h0);
    chk("rst_cause",   32'(wake_cause_o),     32'h0);
    reset_i = 1'b0;

    // enable thread 2
    csr(2, 1'b1); clk1(); idle();
    chk("en_t2", 32'(thread_enabled_o), 32'h5);

    // T0 blocks with no timeout; wrong-line snoop ignored; same-line snoop wakes after 5 cycles
    mwait(0, 40'h80_0000_0040, 0); clk1(); idle();
    for (int k = 1; k <= 5; k++) begin
      chk("snp_blocked", 32'(thread_blocked_o[0]), 32'h1);
      chk("snp_nopulse", 32'(wake_pulse_o), 32'h0);
      if (k == 1) snoop(40'h80_0000_0080);
      if (k == 5) snoop(40'h80_0000_0078);
      clk1(); idle();
    end
    chk("snp_pulse", 32'(wake_pulse_o), 32'h1);
    chk("snp_cause", 32'(wake_cause_o[1:0]), 32'h0);
    chk("snp_unblk", 32'(thread_blocked_o), 32'h0);
    clk1();
    chk("snp_pulse_1cyc", 32'(wake_pulse_o), 32'h0);

    // T0 timeout 3: exactly three blocked cycles
    mwait(0, 40'h80_0000_0040, 3); clk1(); idle();
    for (int k = 1; k <= 3; k++) begin
      chk("tmo_blocked", 32'(thread_blocked_o[0]), 32'h1);
      clk1();
    end
    chk("tmo_pulse", 32'(wake_pulse_o), 32'h1);
    chk("tmo_cause", 32'(wake_cause_o[1:0]), 32'h1);
    chk("tmo_unblk", 32'(thread_blocked_o), 32'h0);

    // timeout of 1: a single blocked cycle
    mwait(0, 40'h80_0000_0040, 1); clk1(); idle();
    chk("tmo1_blocked", 32'(thread_blocked_o), 32'h1);
    clk1();
    chk("tmo1_pulse", 32'(wake_pulse_o), 32'h1);
    chk("tmo1_cause", 32'(wake_cause_o[1:0]), 32'h1);

    // T1 and T2 on the same line, one snoop wakes both
    csr(1, 1'b1); clk1(); idle();
    mwait(1, 40'h10_0000_0000, 0); clk1(); idle();
    mwait(2, 40'h10_0000_0020, 0); clk1(); idle();
    chk("two_blocked", 32'(thread_blocked_o), 32'h6);
    snoop(40'h10_0000_003f); clk1(); idle();
    chk("two_pulse", 32'(wake_pulse_o), 32'h6);
    chk("two_cause1", 32'(wake_cause_o[3:2]), 32'h0);
    chk("two_cause2", 32'(wake_cause_o[5:4]), 32'h0);
    chk("two_unblk", 32'(thread_blocked_o), 32'h0);

    // lost-wakeup guard: mwait plus matching snoop in one cycle
    mwait(0, 40'h20_0000_0000, 0); snoop(40'h20_0000_0010); clk1(); idle();
    chk("guard_blocked", 32'(thread_blocked_o), 32'h0);
    chk("guard_pulse", 32'(wake_pulse_o), 32'h1);
    chk("guard_cause", 32'(wake_cause_o[1:0]), 32'h0);
    clk1();
    // explicit wake beats snoop
    mwait(0, 40'h30_0000_0000, 0); clk1(); idle();
    chk("ipi_blocked", 32'(thread_blocked_o), 32'h1);
    wake_v_i = 1'b1; wake_tid_i = 2'd0; snoop(40'h30_0000_0000); clk1(); idle();
    chk("ipi_pulse", 32'(wake_pulse_o), 32'h1);
    chk("ipi_cause", 32'(wake_cause_o[1:0]), 32'h2);

    // disable a blocked thread, re-enable, stale line ignored
    mwait(1, 40'h40_0000_0000, 0); clk1(); idle();
    chk("dis_blocked", 32'(thread_blocked_o), 32'h2);
    csr(1, 1'b0); clk1(); idle();
    chk("dis_enabled", 32'(thread_enabled_o), 32'h5);
    chk("dis_blocked0", 32'(thread_blocked_o), 32'h0);
    chk("dis_nopulse", 32'(wake_pulse_o), 32'h0);
    csr(1, 1'b1); clk1(); idle();
    chk("reen_enabled", 32'(thread_enabled_o), 32'h7);
    snoop(40'h40_0000_0000); clk1(); idle();
    chk("stale_nopulse", 32'(wake_pulse_o), 32'h0);
    chk("stale_blocked", 32'(thread_blocked_o), 32'h0);

    // randomized phase, checked by the model
    for (int i = 0; i < 4000; i++) begin
      reset_i = ($urandom_range(0, 299) == 0);
      csr_en_v_i   = ($urandom_range(0, 9) == 0);
      csr_en_tid_i = 2'($urandom_range(0, 3));
      csr_en_val_i = ($urandom_range(0, 3) != 0);
      mwait_v_i    = ($urandom_range(0, 9) < 3);
      mwait_tid_i  = 2'($urandom_range(0, 3));
      mwait_addr_i = 40'h80_0000_0000 | (40'($urandom_range(0, 3)) << 6) | 40'($urandom_range(0, 63));
      mwait_timeout_i = 16'($urandom_range(0, 8));
      snoop_v_i    = ($urandom_range(0, 9) < 2);
      snoop_addr_i = 40'h80_0000_0000 | (40'($urandom_range(0, 4)) << 6) | 40'($urandom_range(0, 63));
      wake_v_i     = ($urandom_range(0, 19) == 0);
      wake_tid_i   = 2'($urandom_range(0, 3));
      clk1();
    end
    reset_i = 1'b0;
    idle();
    clk1(); clk1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
